// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer with load/start/stop/tick control and a one-cycle
// done pulse on expiry. Optional mm:ss mode makes digit 1 count mod-6.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | count loaded or cleared, not counting; start needs nonzero count
// RUN    | counting down by one on each tick
// PAUSE  | count held; start resumes, stop cancels (count -> 0, IDLE)
// DONE   | count reached zero; stop returns to IDLE, start is ignored

module bcd_countdown_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int MMSS_MODE  = 1
) (
    input  logic                    clk,
    input  logic                    clear_n,
    input  logic                    load,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    tick,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic                    zero,
    output logic                    running,
    output logic                    done
);

    localparam int W = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   count_q, count_d;
    logic           done_q,  done_d;
    logic [W-1:0]   count_dec;

    // Largest legal value of digit i: 5 for the tens-of-seconds digit in mm:ss mode.
    function automatic logic [3:0] digit_max(input int i);
        return ((MMSS_MODE != 0) && (i == 1)) ? 4'd5 : 4'd9;
    endfunction

    function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (v[4*i +: 4] > digit_max(i)) begin
                r[4*i +: 4] = digit_max(i);
            end
        end
        return r;
    endfunction

    // Ripple-borrow decrement: a zero digit wraps to its max and keeps borrowing.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = digit_max(i);
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // State, count and done pulse registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!clear_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            done_q  <= done_d;
        end
    end

    // Next state: load > stop > start > tick; done pulses only on the expiring tick.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        count_dec = bcd_dec(count_q);

        if (load) begin
            count_d = bcd_clamp(digits_in);
            state_d = S_IDLE;
        end else if (stop) begin
            case (state_q)
                S_RUN:   state_d = S_PAUSE;
                S_PAUSE: begin
                    count_d = '0;
                    state_d = S_IDLE;
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = state_q;
            endcase
        end else if (start) begin
            if ((state_q == S_IDLE && count_q != '0) || state_q == S_PAUSE) begin
                state_d = S_RUN;
            end
        end else if (tick && state_q == S_RUN) begin
            count_d = count_dec;
            if (count_dec == '0) begin
                state_d = S_DONE;
                done_d  = 1'b1;
            end
        end
    end

    assign digits_out = count_q;
    assign zero       = (count_q == '0);
    assign running    = (state_q == S_RUN);
    assign done       = done_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Bench for bcd_countdown_timer: an mm:ss instance and an all-decimal
// instance share stimulus and are compared against an integer-valued model.

module tb_bcd_countdown_timer;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic        clk = 1'b0;
    logic        clear_n = 1'b0;
    logic        load = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        tick = 1'b0;
    logic [15:0] digits_in = '0;
    logic [15:0] dout_a, dout_b;
    logic        zero_a, zero_b, running_a, running_b, done_a, done_b;

    int n_vec = 0;
    int n_err = 0;

    int m_st   [2];
    int m_val  [2];
    bit m_done [2];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.NUM_DIGITS(4), .MMSS_MODE(1)) dut_a (
        .clk(clk), .clear_n(clear_n), .load(load), .start(start), .stop(stop),
        .tick(tick), .digits_in(digits_in), .digits_out(dout_a),
        .zero(zero_a), .running(running_a), .done(done_a)
    );

    bcd_countdown_timer #(.NUM_DIGITS(4), .MMSS_MODE(0)) dut_b (
        .clk(clk), .clear_n(clear_n), .load(load), .start(start), .stop(stop),
        .tick(tick), .digits_in(digits_in), .digits_out(dout_b),
        .zero(zero_b), .running(running_b), .done(done_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // BCD <-> total count: mm:ss is minutes*60+seconds, otherwise plain decimal.
    function automatic int to_int(input logic [15:0] b, input bit mmss);
        int d [4];
        for (int i = 0; i < 4; i++) d[i] = int'(b[4*i +: 4]);
        if (mmss) return (d[3]*10 + d[2])*60 + d[1]*10 + d[0];
        return d[3]*1000 + d[2]*100 + d[1]*10 + d[0];
    endfunction

    function automatic logic [15:0] to_bcd(input int v, input bit mmss);
        int d [4];
        if (mmss) begin
            d[0] = (v % 60) % 10;
            d[1] = (v % 60) / 10;
            d[2] = (v / 60) % 10;
            d[3] = (v / 60) / 10;
        end else begin
            d[0] = v % 10;
            d[1] = (v / 10) % 10;
            d[2] = (v / 100) % 10;
            d[3] = v / 1000;
        end
        return {d[3][3:0], d[2][3:0], d[1][3:0], d[0][3:0]};
    endfunction

    function automatic logic [15:0] clamp(input logic [15:0] b, input bit mmss);
        logic [15:0] r;
        int          lim;
        r = b;
        for (int i = 0; i < 4; i++) begin
            lim = (mmss && i == 1) ? 5 : 9;
            if (int'(b[4*i +: 4]) > lim) r[4*i +: 4] = lim[3:0];
        end
        return r;
    endfunction

    task automatic model_edge(input int k, input bit c, input bit ld, input bit sa,
                              input bit sp, input bit tk, input logic [15:0] din);
        bit mmss;
        mmss = (k == 0);
        m_done[k] = 1'b0;
        if (!c) begin
            m_st[k]  = M_IDLE;
            m_val[k] = 0;
        end else if (ld) begin
            m_val[k] = to_int(clamp(din, mmss), mmss);
            m_st[k]  = M_IDLE;
        end else if (sp) begin
            if (m_st[k] == M_RUN) m_st[k] = M_PAUSE;
            else if (m_st[k] == M_PAUSE) begin
                m_val[k] = 0;
                m_st[k]  = M_IDLE;
            end else if (m_st[k] == M_DONE) m_st[k] = M_IDLE;
        end else if (sa) begin
            if ((m_st[k] == M_IDLE && m_val[k] != 0) || m_st[k] == M_PAUSE) m_st[k] = M_RUN;
        end else if (tk && m_st[k] == M_RUN) begin
            m_val[k] = m_val[k] - 1;
            if (m_val[k] == 0) begin
                m_st[k]   = M_DONE;
                m_done[k] = 1'b1;
            end
        end
    endtask

    // Apply one cycle of inputs, advance the model, then compare both instances.
    task automatic step(input bit c, input bit ld, input bit sa, input bit sp,
                        input bit tk, input logic [15:0] din);
        clear_n   = c;
        load      = ld;
        start     = sa;
        stop      = sp;
        tick      = tk;
        digits_in = din;
        @(posedge clk);
        for (int k = 0; k < 2; k++) model_edge(k, c, ld, sa, sp, tk, din);
        #1;
        chk("a_digits",  {16'h0, dout_a},  {16'h0, to_bcd(m_val[0], 1'b1)});
        chk("a_zero",    {31'h0, zero_a},    {31'h0, m_val[0] == 0});
        chk("a_running", {31'h0, running_a}, {31'h0, m_st[0] == M_RUN});
        chk("a_done",    {31'h0, done_a},    {31'h0, m_done[0]});
        chk("b_digits",  {16'h0, dout_b},  {16'h0, to_bcd(m_val[1], 1'b0)});
        chk("b_zero",    {31'h0, zero_b},    {31'h0, m_val[1] == 0});
        chk("b_running", {31'h0, running_b}, {31'h0, m_st[1] == M_RUN});
        chk("b_done",    {31'h0, done_b},    {31'h0, m_done[1]});
    endtask

    task automatic idle_cyc();
        step(1, 0, 0, 0, 0, 16'h0);
    endtask

    initial begin
        logic [15:0] din;
        bit c, ld, sa, sp, tk;

        for (int k = 0; k < 2; k++) begin
            m_st[k] = M_IDLE; m_val[k] = 0; m_done[k] = 1'b0;
        end

        // reset state
        step(0, 0, 0, 0, 0, 16'h0);
        chk("rst_digits", {16'h0, dout_a}, 32'h0);
        chk("rst_zero", {31'h0, zero_a}, 32'h1);
        chk("rst_running", {31'h0, running_a}, 32'h0);
        step(1, 0, 1, 0, 0, 16'h0);
        chk("start_zero_ignored", {31'h0, running_a}, 32'h0);

        // 01:00 minus one tick
        step(1, 1, 0, 0, 0, 16'h0100);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 1, 16'h0);
        chk("mmss_borrow", {16'h0, dout_a}, 32'h0059);
        chk("mmss_running", {31'h0, running_a}, 32'h1);
        chk("dec_borrow", {16'h0, dout_b}, 32'h0099);

        // expiry: one done pulse, no wrap on further ticks
        step(1, 1, 0, 0, 0, 16'h0001);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 1, 16'h0);
        chk("expire_digits", {16'h0, dout_a}, 32'h0);
        chk("expire_done", {31'h0, done_a}, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 0, 0, 1, 16'h0);
            chk("expire_nowrap", {16'h0, dout_a}, 32'h0);
            chk("expire_single_done", {31'h0, done_a}, 32'h0);
        end
        step(1, 0, 1, 0, 0, 16'h0);
        chk("done_start_ignored", {31'h0, running_a}, 32'h0);
        step(1, 0, 0, 1, 0, 16'h0);

        // load clamping
        step(1, 1, 0, 0, 0, 16'h9A7F);
        chk("clamp_mmss", {16'h0, dout_a}, 32'h9959);
        chk("clamp_dec", {16'h0, dout_b}, 32'h9979);

        // pause, resume, cancel
        step(1, 1, 0, 0, 0, 16'h0230);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 1, 0, 16'h0);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1, 16'h0);
        chk("pause_hold", {16'h0, dout_a}, 32'h0230);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 1, 16'h0);
        chk("resume_tick", {16'h0, dout_a}, 32'h0229);
        step(1, 0, 0, 1, 0, 16'h0);
        step(1, 0, 0, 1, 0, 16'h0);
        chk("cancel_digits", {16'h0, dout_a}, 32'h0);
        chk("cancel_running", {31'h0, running_a}, 32'h0);

        // same-cycle priority
        step(1, 1, 0, 0, 0, 16'h0500);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 1, 0, 0, 1, 16'h0042);
        chk("load_over_tick", {16'h0, dout_a}, 32'h0042);
        chk("load_to_idle", {31'h0, running_a}, 32'h0);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 0, 1, 1, 0, 16'h0);
        chk("stop_over_start", {31'h0, running_a}, 32'h0);
        step(1, 0, 0, 0, 1, 16'h0);
        chk("paused_after_both", {16'h0, dout_a}, 32'h0042);

        // clear mid-RUN and while done is pending
        step(1, 1, 0, 0, 0, 16'h0105);
        step(1, 0, 1, 0, 0, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        chk("clr_run_digits", {16'h0, dout_a}, 32'h0);
        chk("clr_run_zero", {31'h0, zero_a}, 32'h1);
        chk("clr_run_running", {31'h0, running_a}, 32'h0);
        chk("clr_run_done", {31'h0, done_a}, 32'h0);
        step(1, 1, 0, 0, 0, 16'h0001);
        step(1, 0, 1, 0, 0, 16'h0);
        step(1, 0, 0, 0, 1, 16'h0);
        step(0, 0, 0, 0, 1, 16'h0);
        chk("clr_done_pulse", {31'h0, done_a}, 32'h0);
        idle_cyc();

        // randomized traffic
        for (int n = 0; n < 1500; n++) begin
            c  = ($urandom_range(0, 63) != 0);
            ld = ($urandom_range(0, 15) == 0);
            sp = ($urandom_range(0, 15) == 0);
            sa = ($urandom_range(0, 7) == 0);
            tk = ($urandom_range(0, 1) == 1);
            if ($urandom_range(0, 1) == 1) din = 16'($urandom_range(0, 3)) | (($urandom_range(0, 3) == 0) ? 16'h0010 : 16'h0);
            else din = 16'($urandom);
            step(c, ld, sa, sp, tk, din);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
